// File: rtl/mmu_cache_nway.sv
// mmu_cache_nway: N-way set-associative MMU page cache. Holds CPN tags and
// 16-bit CD data per index, picks victims round-robin and runs a clear sweep
// over every index after reset or on CCLR. Lookup responses are registered.
// Ports: sysclk/sys_rst; con/fmiss/lshadow qualifiers; lk_* lookup request
// with rsp_valid/hit/hit_way/rd_data response; fill_* line write;
// cclr_req/clr_busy sweep control; led1 cache-active indicator.
// Optional macro MMU_CACHE_STATS_EN adds hit_cnt/miss_cnt outputs.
module mmu_cache_nway #(
    parameter int WAYS    = 2,
    parameter int INDEX_W = 11,
    parameter int TAG_W   = 14,
    parameter int DATA_W  = 16,
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic               sysclk,
    input  logic               sys_rst,
    input  logic               con,
    input  logic               fmiss,
    input  logic               lshadow,
    input  logic               lk_valid,
    output logic               lk_ready,
    input  logic [INDEX_W-1:0] lk_index,
    input  logic [TAG_W-1:0]   lk_tag,
    output logic               rsp_valid,
    output logic               hit,
    output logic [WAY_W-1:0]   hit_way,
    output logic [DATA_W-1:0]  rd_data,
    input  logic               fill_valid,
    input  logic [INDEX_W-1:0] fill_index,
    input  logic [TAG_W-1:0]   fill_tag,
    input  logic [DATA_W-1:0]  fill_data,
    input  logic               cclr_req,
    output logic               clr_busy,
    output logic               led1
`ifdef MMU_CACHE_STATS_EN
    ,
    output logic [15:0]        hit_cnt,
    output logic [15:0]        miss_cnt
`endif
);

    localparam int DEPTH = 1 << INDEX_W;

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t             state_q, state_d;
    logic [INDEX_W-1:0] ptr_q, ptr_d;
    logic [WAY_W-1:0]   victim_q, victim_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               hit_q, hit_d;
    logic [WAY_W-1:0]   hit_way_q, hit_way_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic               led1_q, led1_d;

    logic [TAG_W-1:0]   tag_mem   [WAYS][DEPTH];
    logic [DATA_W-1:0]  data_mem  [WAYS][DEPTH];
    logic [DEPTH-1:0]   valid_mem [WAYS];

    logic               lk_accept;
    logic               lk_hit;
    logic [WAY_W-1:0]   lk_way;
    logic               fill_go;
    logic               fill_match;
    logic [WAY_W-1:0]   fill_match_way;
    logic               fill_free;
    logic [WAY_W-1:0]   fill_free_way;
    logic [WAY_W-1:0]   fill_way;
    logic               clr_start;

    assign clr_busy  = (state_q == ST_CLEAR);
    assign lk_ready  = (state_q == ST_IDLE);
    assign lk_accept = lk_valid & lk_ready;
    assign clr_start = lk_ready & cclr_req;
    // A clear request in the same cycle drops the fill.
    assign fill_go   = lk_ready & fill_valid & con & ~lshadow & ~cclr_req;

    // Downward scans so the lowest matching/free way wins.
    always_comb begin
        lk_hit         = 1'b0;
        lk_way         = '0;
        fill_match     = 1'b0;
        fill_match_way = '0;
        fill_free      = 1'b0;
        fill_free_way  = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (valid_mem[i][lk_index] &&
                tag_mem[i][lk_index] == lk_tag) begin
                lk_hit = 1'b1;
                lk_way = WAY_W'(i);
            end
            if (valid_mem[i][fill_index] &&
                tag_mem[i][fill_index] == fill_tag) begin
                fill_match     = 1'b1;
                fill_match_way = WAY_W'(i);
            end
            if (!valid_mem[i][fill_index]) begin
                fill_free     = 1'b1;
                fill_free_way = WAY_W'(i);
            end
        end
    end

    always_comb begin
        fill_way = victim_q;
        victim_d = victim_q;
        if (fill_match) begin
            fill_way = fill_match_way;
        end else if (fill_free) begin
            fill_way = fill_free_way;
        end else if (fill_go) begin
            victim_d = (victim_q == WAY_W'(WAYS - 1)) ? '0 : victim_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ST_CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == '1) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (cclr_req) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
        endcase
    end

    // Memory is read combinationally before the edge, so a fill in the same
    // cycle is not visible to the lookup.
    always_comb begin
        rsp_valid_d = lk_accept;
        hit_d       = lk_accept & con & ~fmiss & ~lshadow & lk_hit;
        hit_way_d   = hit_d ? lk_way : '0;
        rd_data_d   = hit_d ? data_mem[lk_way][lk_index] : '0;
        led1_d      = con & ~clr_busy;
    end

    always_ff @(posedge sysclk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= ST_CLEAR;
            ptr_q       <= '0;
            victim_q    <= '0;
            rsp_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            hit_way_q   <= '0;
            rd_data_q   <= '0;
            led1_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            victim_q    <= victim_d;
            rsp_valid_q <= rsp_valid_d;
            hit_q       <= hit_d;
            hit_way_q   <= hit_way_d;
            rd_data_q   <= rd_data_d;
            led1_q      <= led1_d;
        end
    end

    always_ff @(posedge sysclk) begin
        if (fill_go) begin
            tag_mem[fill_way][fill_index]  <= fill_tag;
            data_mem[fill_way][fill_index] <= fill_data;
        end
    end

    // Only valid bits are cleared; tags and data may hold stale values.
    always_ff @(posedge sysclk) begin
        if (clr_busy) begin
            for (int w = 0; w < WAYS; w++) valid_mem[w][ptr_q] <= 1'b0;
        end else if (fill_go) begin
            valid_mem[fill_way][fill_index] <= 1'b1;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign hit       = hit_q;
    assign hit_way   = hit_way_q;
    assign rd_data   = rd_data_q;
    assign led1      = led1_q;

`ifdef MMU_CACHE_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (clr_start) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end else if (rsp_valid_q) begin
            if (hit_q && hit_cnt_q != 16'hFFFF)
                hit_cnt_d = hit_cnt_q + 16'd1;
            if (!hit_q && miss_cnt_q != 16'hFFFF)
                miss_cnt_d = miss_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge sysclk or posedge sys_rst) begin
        if (sys_rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule
